// File: rtl/vga_sync_gen.sv
// VGA timing generator: advances one pixel per clk with pix_en high and
// produces registered hsync/vsync, video_on, pixel coordinates and
// line/frame start pulses, all decoded from the next-state counters.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Decode bounds carry one spare bit so a sync end equal to the total
  // (zero back porch) still compares correctly.
  localparam logic [CNT_W:0] H_VIS_END = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] HS_BEG    = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_VIS_END = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] VS_BEG    = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;

  // Next-state pixel/line counters: advance only on a pixel tick.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) v_cnt_d = '0;
        else                   v_cnt_d = v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Output decode from the next-state counters so outputs line up with them.
  always_comb begin
    h_ext         = {1'b0, h_cnt_d};
    v_ext         = {1'b0, v_cnt_d};
    video_on_d    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    hsync_d       = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
    pix_x_d       = video_on_d ? h_cnt_d : '0;
    pix_y_d       = video_on_d ? v_cnt_d : '0;
    // Pulses fire only on the advancing edge that wraps h_cnt, so they
    // last one clk even with pix_en held high.
    line_start_d  = pix_en && (h_cnt_q == H_LAST);
    frame_start_d = line_start_d && (v_cnt_q == V_LAST);
  end

  // State and output registers; reset parks the counters one pixel before (0,0).
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
